// File: rtl/sprite_map_compositor_pkg.sv
// Shared constants, types and address helpers for the map/sprite compositor
// and the timing-generator consumers that must delay-match against it.
package sprite_map_compositor_pkg;

  typedef enum logic [1:0] {DOWN = 2'd0, UP = 2'd1, LEFT = 2'd2, RIGHT = 2'd3} dir_t;
  typedef enum logic {IDLE = 1'b0, WALK = 1'b1} anim_state_t;

  localparam int MAP_W           = 320;
  localparam int MAP_H           = 240;
  localparam int SPR_W           = 16;
  localparam int SPR_H           = 16;
  localparam int SCALE_SH        = 1;
  localparam logic [7:0] TRANSPARENT = 8'h00;
  localparam int SPR_FRAME_WORDS = 256;
  localparam int PIPE_LAT        = 3;

  // Sprite footprint on screen after upscaling.
  localparam int SPR_SCR_W = SPR_W << SCALE_SH;
  localparam int SPR_SCR_H = SPR_H << SCALE_SH;

  function automatic logic [18:0] map_index(input logic [9:0] x, input logic [9:0] y);
    logic [18:0] row;
    logic [18:0] col;
    row = 19'(y >> SCALE_SH);
    col = 19'(x >> SCALE_SH);
    return row * 19'(MAP_W) + col;
  endfunction

endpackage

// File: rtl/sprite_anim_ctrl.sv
// Per-frame character position latch and walk-animation step sequencer.
// Everything here only moves on frame_start so a frame never renders torn.
module sprite_anim_ctrl
  import sprite_map_compositor_pkg::*;
#(
  parameter int N_STEP   = 3,
  parameter int ANIM_DIV = 8,
  localparam int STEP_W  = (N_STEP > 1) ? $clog2(N_STEP) : 1,
  localparam int DIV_W   = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic [9:0]        char_x,
  input  logic [9:0]        char_y,
  input  logic [1:0]        char_dir,
  input  logic              char_moving,
  output logic [9:0]        sx,
  output logic [9:0]        sy,
  output dir_t              sdir,
  output logic [STEP_W-1:0] step
);

  anim_state_t       state, state_nx;
  logic [STEP_W-1:0] step_nx;
  logic [DIV_W-1:0]  div, div_nx;

  // The moving flag is consumed on the same edge it is latched; the FSM
  // state is its shadow from then on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      step  <= '0;
      div   <= '0;
      sx    <= '0;
      sy    <= '0;
      sdir  <= DOWN;
    end else if (frame_start) begin
      state <= state_nx;
      step  <= step_nx;
      div   <= div_nx;
      sx    <= char_x;
      sy    <= char_y;
      sdir  <= dir_t'(char_dir);
    end
  end

  always_comb begin
    state_nx = state;
    step_nx  = step;
    div_nx   = div;
    case (state)
      IDLE: begin
        step_nx = '0;
        div_nx  = '0;
        if (char_moving) state_nx = WALK;
      end
      WALK: begin
        // Stopping wins over a simultaneous divider wrap.
        if (!char_moving) begin
          state_nx = IDLE;
          step_nx  = '0;
          div_nx   = '0;
        end else if (div == DIV_W'(ANIM_DIV - 1)) begin
          div_nx  = '0;
          step_nx = (step == STEP_W'(N_STEP - 1)) ? '0 : step + STEP_W'(1);
        end else begin
          div_nx = div + DIV_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: rtl/sprite_map_compositor.sv
// Three-stage pixel pipeline: address generation, RAM read, and sprite-over-map
// composite with palette index 0 as transparent; syncs are delay-matched.
module sprite_map_compositor
  import sprite_map_compositor_pkg::*;
#(
  parameter int N_STEP   = 3,
  parameter int ANIM_DIV = 8,
  localparam int STEP_W  = (N_STEP > 1) ? $clog2(N_STEP) : 1
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        disp_en_in,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic        frame_start,
  input  logic [9:0]  char_x,
  input  logic [9:0]  char_y,
  input  logic [1:0]  char_dir,
  input  logic        char_moving,
  output logic [18:0] map_addr,
  input  logic [7:0]  map_data,
  output logic [12:0] spr_addr,
  input  logic [7:0]  spr_data,
  output logic [7:0]  pix_idx,
  output logic        disp_en_out,
  output logic        hs_out,
  output logic        vs_out
);

  localparam int LX_W = $clog2(SPR_W);
  localparam int LY_W = $clog2(SPR_H);

  logic [9:0]        sx, sy;
  dir_t              sdir;
  logic [STEP_W-1:0] step;

  sprite_anim_ctrl #(.N_STEP(N_STEP), .ANIM_DIV(ANIM_DIV)) u_anim (
    .clk         (Clk),
    .rst_n       (Reset_n),
    .frame_start (frame_start),
    .char_x      (char_x),
    .char_y      (char_y),
    .char_dir    (char_dir),
    .char_moving (char_moving),
    .sx          (sx),
    .sy          (sy),
    .sdir        (sdir),
    .step        (step)
  );

  function automatic logic [7:0] composite(input logic vld, input logic hit,
                                           input logic [7:0] spr, input logic [7:0] map);
    if (!vld)                          return 8'h00;
    else if (hit && spr != TRANSPARENT) return spr;
    else                               return map;
  endfunction

  // An 11-bit unsigned difference turns "left of / above the sprite" into a
  // huge value, so edge sprites clip instead of wrapping around the screen.
  logic [10:0]   dx, dy;
  logic          hit;
  logic [LX_W-1:0] lx;
  logic [LY_W-1:0] ly;
  logic [12:0]   frame_sel;

  assign dx        = {1'b0, DrawX} - {1'b0, sx};
  assign dy        = {1'b0, DrawY} - {1'b0, sy};
  assign hit       = disp_en_in && (dx < 11'(SPR_SCR_W)) && (dy < 11'(SPR_SCR_H));
  assign lx        = LX_W'(dx >> SCALE_SH);
  assign ly        = LY_W'(dy >> SCALE_SH);
  assign frame_sel = 13'(sdir) * 13'(N_STEP) + 13'(step);

  logic hit_p0, vld_p0, hs_p0, vs_p0;
  logic hit_p1, vld_p1, hs_p1, vs_p1;

  // Stage 1: address generation
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      map_addr <= '0;
      spr_addr <= '0;
      hit_p0   <= 1'b0;
      vld_p0   <= 1'b0;
      hs_p0    <= 1'b1;
      vs_p0    <= 1'b1;
    end else begin
      map_addr <= disp_en_in ? map_index(DrawX, DrawY) : '0;
      spr_addr <= hit ? frame_sel * 13'(SPR_FRAME_WORDS) + 13'(ly) * 13'(SPR_W) + 13'(lx)
                      : '0;
      hit_p0   <= hit;
      vld_p0   <= disp_en_in;
      hs_p0    <= hs_in;
      vs_p0    <= vs_in;
    end
  end

  // Stage 2: RAMs capture the addresses; control rides alongside
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hit_p1 <= 1'b0;
      vld_p1 <= 1'b0;
      hs_p1  <= 1'b1;
      vs_p1  <= 1'b1;
    end else begin
      hit_p1 <= hit_p0;
      vld_p1 <= vld_p0;
      hs_p1  <= hs_p0;
      vs_p1  <= vs_p0;
    end
  end

  // Stage 3: composite
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pix_idx     <= 8'h00;
      disp_en_out <= 1'b0;
      hs_out      <= 1'b1;
      vs_out      <= 1'b1;
    end else begin
      pix_idx     <= composite(vld_p1, hit_p1, spr_data, map_data);
      disp_en_out <= vld_p1;
      hs_out      <= hs_p1;
      vs_out      <= vs_p1;
    end
  end

endmodule
